// File: rtl/gates7_logic_unit.sv
// Bitwise logic unit with valid/ready handshake, accumulator feedback,
// registered result flags and a completed-handshake counter.
module gates7_logic_unit #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   f,
    output logic               zero,
    output logic               parity,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             deliver;

    // The slot frees up in the same cycle the consumer takes the result.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;
    assign opb      = acc_en ? acc : b;

    always_comb begin
        res = '0;
        unique case (op)
            OP_AND:  res = a & opb;
            OP_OR:   res = a | opb;
            OP_NAND: res = ~(a & opb);
            OP_NOR:  res = ~(a | opb);
            OP_XOR:  res = a ^ opb;
            OP_XNOR: res = ~(a ^ opb);
            OP_NOTA: res = ~a;
            OP_PASS: res = a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            f         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            f         <= res;
            zero      <= ~|res;
            parity    <= ^res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins; the operation itself already saw the old value via opb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept) begin
            acc <= res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (deliver) begin
            op_count <= op_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gates7_logic_unit.sv
// Scoreboard bench for gates7_logic_unit: stimulus pushes expected
// results, a negedge monitor pops them on each output handshake.
module tb_gates7_logic_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       acc_en = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] f;
    logic       zero;
    logic       parity;
    logic [3:0] op_count;

    int tests = 0;
    int fails = 0;

    logic [9:0] sb[$];

    gates7_logic_unit #(.WIDTH(8), .COUNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .zero(zero), .parity(parity),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got f=%0h expected none", f);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                check("result_f", f, e[9:2]);
                check("result_zero", zero, e[1]);
                check("result_parity", parity, e[0]);
            end
        end
    end

    // Present one operand set; push its expected result when it is taken.
    task automatic issue(input logic [2:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input logic en,
                         input logic clr, input logic [7:0] ef);
        bit taken;
        taken = 1'b0;
        op = o; a = av; b = bv; acc_en = en; acc_clr = clr;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            if (in_ready) taken = 1'b1;
        end
        if (!taken) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1");
        end else begin
            sb.push_back({ef, ~|ef, ^ef});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
        acc_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", sb.size(), 0);
    endtask

    logic [7:0] sweep_exp [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00,
                                  8'hFF, 8'h00, 8'h3A, 8'hC5};
    logic [7:0] acc_a [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    logic [7:0] acc_f [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_f", f, 0);
        check("rst_zero", zero, 1);
        check("rst_parity", parity, 0);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++)
            issue(3'(i), 8'hC5, 8'h3A, 1'b0, 1'b0, sweep_exp[i]);
        drain();
        check("sweep_count", op_count, 8);

        issue(3'd1, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF);
        out_ready = 1'b0;
        op = 3'd7; a = 8'h5A; b = 8'h00; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_f_hold", f, 8'hFF);
            check("bp_count_hold", op_count, 8);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'd7, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A);
        check("bp_count_step", op_count, 9);
        check("bp_next_loaded", f, 8'h5A);
        drain();

        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(3'd1, acc_a[i], 8'hFF, 1'b1, 1'b0, acc_f[i]);
        issue(3'd4, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hF0);
        issue(3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00);
        drain();
        check("count_wrap16", op_count, 0);

        out_ready = 1'b0;
        issue(3'd7, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C);
        check("mid_out_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_f", f, 0);
        check("async_zero", zero, 1);
        check("async_parity", parity, 0);
        check("async_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("discard_count", op_count, 0);
        check("discard_valid", out_valid, 0);

        for (int i = 0; i < 17; i++)
            issue(3'd7, 8'(i), 8'h00, 1'b0, 1'b0, 8'(i));
        drain();
        check("wrap_17", op_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gates7_logic_unit.md
GATES7_LOGIC_UNIT -- requirements
Module: gates7_logic_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, 1 to 64.
REQ-002 Parameter COUNT_W, default 16: completed-operation counter width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  unit can accept an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; ignored when acc_en=1.
REQ-009 op  input  3  function select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A.
REQ-010 acc_en  input  1  use the accumulator register as operand B.
REQ-011 acc_clr  input  1  synchronous accumulator clear.
REQ-012 out_valid  output  1  result register holds an undelivered result.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 f  output  WIDTH  registered result.
REQ-015 zero  output  1  registered flag, 1 when f is all zeros.
REQ-016 parity  output  1  registered flag, XOR reduction of f.
REQ-017 op_count  output  COUNT_W  number of completed output handshakes.

Function
REQ-018 Input accept occurs when in_valid=1 and in_ready=1; in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-019 Latency SHALL be 1 cycle: on accept, f, zero, and parity load from the selected function at that edge, and out_valid=1 the next cycle.
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-021 When out_valid=1 and out_ready=0: f, zero, parity, and out_valid SHALL hold; no accept occurs.
REQ-022 out_valid SHALL clear when out_ready=1 and no accept occurs in the same cycle.
REQ-023 Operand B SHALL be acc when acc_en=1 at accept, else b.
REQ-024 Ops 6 and 7 SHALL ignore operand B.
REQ-025 All functions SHALL be bitwise over WIDTH bits, with no carries.
REQ-026 acc (internal, WIDTH bits) SHALL load the computed result on every accept, regardless of acc_en.
REQ-027 acc_clr=1 SHALL set acc to 0 at the edge and take priority over the REQ-026 update.
REQ-028 If accept and acc_clr occur in the same cycle, the operation SHALL use the pre-clear acc value, and acc SHALL end at 0.
REQ-029 acc_clr SHALL NOT affect f, out_valid, or op_count.
REQ-030 op_count SHALL increment by 1 on each cycle with out_valid=1 and out_ready=1, wrapping from all-ones to 0.
REQ-031 in_valid=0 SHALL cause no state change except the out_valid clear of REQ-022 and the count of REQ-030.

Reset
REQ-032 While rst=1: out_valid=0, f=0, zero=1, parity=0, acc=0, op_count=0, regardless of clk.
REQ-033 in_ready SHALL read 1 during and immediately after reset.
REQ-034 Reset asserted mid-transaction SHALL discard the pending result; no handshake completes for it.
REQ-035 After rst deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-036 The bench SHALL cover these directed scenarios (WIDTH=8):
- Each op with a=8'hC5, b=8'h3A, out_ready=1 -> f = 00, FF, FF, 00, FF, 00, 3A, C5 respectively, one cycle after accept; zero and parity correct for each.
- Back-pressure: accept a=8'h0F, b=8'hF0, op=1 (OR), then hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, f=FF held, op_count unchanged; on out_ready=1, op_count+1 and the next operand set is accepted in the same cycle.
- Accumulate: acc_clr pulse, then op=1 with acc_en=1 and a = 01, 02, 04, 08 -> f = 01, 03, 07, 0F.
- Simultaneous acc_clr and accept with acc=8'h0F, op=4 (XOR), a=8'hFF, acc_en=1 -> f=F0; acc=00 afterward.
- Counter wrap with COUNT_W=4: 17 handshakes -> op_count=1.
- Async reset asserted between clock edges while out_valid=1 -> outputs take REQ-032 values immediately, with no further handshake.
